// File: rtl/conway_pkg.sv
// Shared types for the 16x16 toroidal life engine and its board loader.
package conway_pkg;

  localparam int CONWAY_ROWS  = 16;
  localparam int CONWAY_COLS  = 16;
  localparam int CONWAY_CELLS = CONWAY_ROWS * CONWAY_COLS;

  typedef logic [CONWAY_COLS-1:0]  conway_row_t;
  typedef logic [CONWAY_CELLS-1:0] conway_board_t;

  typedef enum logic {
    LDR_FILL,
    LDR_LOAD
  } conway_ldr_state_e;

endpackage

// File: rtl/conway_board_loader.sv
// Collects ROWS row transfers into a shadow frame and hands the completed
// board to the life engine with a single-cycle load strobe.
module conway_board_loader
  import conway_pkg::*;
#(
  parameter int ROWS = CONWAY_ROWS,
  parameter int COLS = CONWAY_COLS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [COLS-1:0]      in_row,
  input  logic                 in_last,
  output logic                 load,
  output logic [ROWS*COLS-1:0] data,
  output logic                 frame_err,
  output logic [7:0]           frame_count
);

  localparam int                IDX_W    = $clog2(ROWS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(ROWS - 1);

  conway_ldr_state_e      state;
  logic [IDX_W-1:0]       row_idx;
  logic [ROWS*COLS-1:0]   shadow;
  logic [ROWS*COLS-1:0]   shadow_merged;
  logic                   at_last_row;

  assign in_ready    = (state == LDR_FILL);
  assign at_last_row = (row_idx == LAST_IDX);

  // The final row has to reach data on the same edge it is accepted.
  always_comb begin
    shadow_merged = shadow;
    shadow_merged[COLS*row_idx +: COLS] = in_row;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= LDR_FILL;
      row_idx     <= '0;
      shadow      <= '0;
      data        <= '0;
      load        <= 1'b0;
      frame_err   <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      load      <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        LDR_FILL: begin
          if (in_valid) begin
            if (in_last && at_last_row) begin
              shadow      <= shadow_merged;
              data        <= shadow_merged;
              load        <= 1'b1;
              row_idx     <= '0;
              frame_count <= frame_count + 8'd1;
              state       <= LDR_LOAD;
            end else if (in_last != at_last_row) begin
              // Short or long frame: drop the partial rows, keep the old board.
              frame_err <= 1'b1;
              row_idx   <= '0;
            end else begin
              shadow  <= shadow_merged;
              row_idx <= row_idx + 1'b1;
            end
          end
        end
        LDR_LOAD: state <= LDR_FILL;
        default:  state <= LDR_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_conway_board_loader.sv
// Directed bench for conway_board_loader: framing, stalls, errors, reset and wrap.
module tb_conway_board_loader;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [15:0]  in_row = '0;
  logic         in_last = 1'b0;
  logic         load;
  logic [255:0] data;
  logic         frame_err;
  logic [7:0]   frame_count;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int err_cnt = 0;
  int load_cyc[$];
  logic prev_load = 1'b0;

  logic [255:0] diag_b, ones_b, glider_b;

  conway_board_loader dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_row(in_row), .in_last(in_last), .load(load), .data(data),
    .frame_err(frame_err), .frame_count(frame_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && load) begin
      load_cyc.push_back(cyc);
      n_cmp++;
      if (prev_load || frame_err) begin
        n_fail++;
        $display("FAIL load_protocol: prev_load=%0b frame_err=%0b, required 0/0", prev_load, frame_err);
      end
    end
    if (!reset && frame_err) err_cnt++;
    prev_load = load;
  end

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drive_row(input logic [15:0] r, input logic l);
    int guard = 0;
    in_valid = 1'b1;
    in_row = r;
    in_last = l;
    while (!in_ready && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 50) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ready_timeout: in_ready=%0b, required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic send_frame(input logic [255:0] b, input int nrows, input int last_at, input bit stall);
    for (int i = 0; i < nrows; i++) begin
      drive_row(b[16*i +: 16], (i == last_at));
      if (stall && (i == 4 || i == 11) && i != nrows - 1) begin
        repeat (3) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b, required 1", in_ready); end
    n_cmp++; if (load !== 1'b0) begin n_fail++; $display("FAIL reset_load: got %0b, required 0", load); end
    n_cmp++; if (data !== '0) begin n_fail++; $display("FAIL reset_data: got %h, required 0", data); end
    n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b, required 0", frame_err); end
    n_cmp++; if (frame_count !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d, required 0", frame_count); end
  endtask

  task automatic test_basic();
    int c0, q0;
    do_reset();
    q0 = load_cyc.size();
    c0 = cyc;
    send_frame(diag_b, 16, 15, 1'b0);
    n_cmp++; if (load !== 1'b1) begin n_fail++; $display("FAIL basic_load: got %0b, required 1", load); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_low: got %0b, required 0", in_ready); end
    n_cmp++; if (data !== diag_b) begin n_fail++; $display("FAIL basic_data: got %h, required %h", data, diag_b); end
    n_cmp++; if (frame_count !== 8'd1) begin n_fail++; $display("FAIL basic_count: got %0d, required 1", frame_count); end
    step();
    n_cmp++; if (load !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_after: load=%0b ready=%0b, required 0/1", load, in_ready); end
    n_cmp++;
    if (load_cyc.size() != q0 + 1) begin n_fail++; $display("FAIL basic_npulse: got %0d, required 1", load_cyc.size() - q0); end
    else if (load_cyc[q0] - c0 != 16) begin n_fail++; $display("FAIL basic_latency: got %0d, required 16", load_cyc[q0] - c0); end
  endtask

  task automatic test_back_to_back();
    int c0, q0;
    do_reset();
    q0 = load_cyc.size();
    c0 = cyc;
    send_frame(ones_b, 16, 15, 1'b0);
    n_cmp++; if (data !== ones_b) begin n_fail++; $display("FAIL b2b_data1: got %h, required %h", data, ones_b); end
    send_frame(glider_b, 16, 15, 1'b0);
    n_cmp++; if (data !== glider_b || load !== 1'b1) begin n_fail++; $display("FAIL b2b_data2: got %h load=%0b, required %h load=1", data, load, glider_b); end
    n_cmp++; if (frame_count !== 8'd2) begin n_fail++; $display("FAIL b2b_count: got %0d, required 2", frame_count); end
    step();
    n_cmp++;
    if (load_cyc.size() != q0 + 2) begin n_fail++; $display("FAIL b2b_npulse: got %0d, required 2", load_cyc.size() - q0); end
    else if (load_cyc[q0] - c0 != 16 || load_cyc[q0+1] - c0 != 33) begin
      n_fail++;
      $display("FAIL b2b_timing: got %0d,%0d, required 16,33", load_cyc[q0] - c0, load_cyc[q0+1] - c0);
    end
  endtask

  task automatic test_stall();
    int c0, q0;
    do_reset();
    q0 = load_cyc.size();
    c0 = cyc;
    send_frame(glider_b, 16, 15, 1'b1);
    n_cmp++; if (data !== glider_b || load !== 1'b1) begin n_fail++; $display("FAIL stall_data: got %h load=%0b, required %h load=1", data, load, glider_b); end
    step();
    n_cmp++;
    if (load_cyc.size() != q0 + 1) begin n_fail++; $display("FAIL stall_npulse: got %0d, required 1", load_cyc.size() - q0); end
    else if (load_cyc[q0] - c0 != 22) begin n_fail++; $display("FAIL stall_latency: got %0d, required 22", load_cyc[q0] - c0); end
  endtask

  task automatic test_short_frame();
    int e0;
    do_reset();
    send_frame(diag_b, 16, 15, 1'b0);
    step();
    e0 = err_cnt;
    send_frame(ones_b, 10, 9, 1'b0);
    n_cmp++; if (frame_err !== 1'b1 || load !== 1'b0) begin n_fail++; $display("FAIL short_err: err=%0b load=%0b, required 1/0", frame_err, load); end
    n_cmp++; if (data !== diag_b || frame_count !== 8'd1) begin n_fail++; $display("FAIL short_hold: data=%h count=%0d, required %h/1", data, frame_count, diag_b); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL short_ready: got %0b, required 1", in_ready); end
    step();
    n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL short_pulse: got %0b, required 0", frame_err); end
    send_frame(glider_b, 16, 15, 1'b0);
    n_cmp++; if (data !== glider_b || load !== 1'b1 || frame_count !== 8'd2) begin n_fail++; $display("FAIL short_recover: data=%h load=%0b count=%0d, required %h/1/2", data, load, frame_count, glider_b); end
    step();
    n_cmp++; if (err_cnt - e0 != 1) begin n_fail++; $display("FAIL short_errcount: got %0d, required 1", err_cnt - e0); end
  endtask

  task automatic test_long_frame();
    do_reset();
    send_frame(ones_b, 16, -1, 1'b0);
    n_cmp++; if (frame_err !== 1'b1 || load !== 1'b0) begin n_fail++; $display("FAIL long_err: err=%0b load=%0b, required 1/0", frame_err, load); end
    n_cmp++; if (data !== '0 || frame_count !== 8'd0) begin n_fail++; $display("FAIL long_hold: data=%h count=%0d, required 0/0", data, frame_count); end
    step();
    send_frame(diag_b, 16, 15, 1'b0);
    n_cmp++; if (data !== diag_b || load !== 1'b1 || frame_count !== 8'd1) begin n_fail++; $display("FAIL long_recover: data=%h load=%0b count=%0d, required %h/1/1", data, load, frame_count, diag_b); end
    step();
  endtask

  task automatic test_reset_mid();
    int e0;
    do_reset();
    send_frame(diag_b, 16, 15, 1'b0);
    step();
    send_frame(ones_b, 8, -1, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++; if (data !== '0 || frame_count !== 8'd0) begin n_fail++; $display("FAIL rstmid_clear: data=%h count=%0d, required 0/0", data, frame_count); end
    n_cmp++; if (dut.row_idx !== 4'd0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_idx: row_idx=%0d ready=%0b, required 0/1", dut.row_idx, in_ready); end
    e0 = err_cnt;
    send_frame(glider_b, 16, 15, 1'b0);
    n_cmp++; if (data !== glider_b || load !== 1'b1 || frame_count !== 8'd1) begin n_fail++; $display("FAIL rstmid_recover: data=%h load=%0b count=%0d, required %h/1/1", data, load, frame_count, glider_b); end
    step();
    n_cmp++; if (err_cnt != e0) begin n_fail++; $display("FAIL rstmid_noerr: got %0d errors, required 0", err_cnt - e0); end
  endtask

  task automatic test_wrap();
    int e0;
    logic [255:0] b;
    do_reset();
    e0 = err_cnt;
    for (int f = 0; f < 256; f++) begin
      for (int r = 0; r < 16; r++) b[16*r +: 16] = 16'($urandom);
      send_frame(b, 16, 15, 1'b0);
      if (f == 254) begin
        n_cmp++; if (frame_count !== 8'd255) begin n_fail++; $display("FAIL wrap_255: got %0d, required 255", frame_count); end
      end
    end
    n_cmp++; if (frame_count !== 8'd0 || load !== 1'b1) begin n_fail++; $display("FAIL wrap_zero: count=%0d load=%0b, required 0/1", frame_count, load); end
    n_cmp++; if (data !== b) begin n_fail++; $display("FAIL wrap_data: got %h, required %h", data, b); end
    step();
    n_cmp++; if (err_cnt != e0) begin n_fail++; $display("FAIL wrap_noerr: got %0d errors, required 0", err_cnt - e0); end
  endtask

  initial begin
    diag_b = '0;
    for (int i = 0; i < 16; i++) diag_b[17*i] = 1'b1;
    ones_b = '1;
    glider_b = '0;
    glider_b[15:0]  = 16'h0002;
    glider_b[31:16] = 16'h0004;
    glider_b[47:32] = 16'h0007;

    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_short_frame();
    test_long_frame();
    test_reset_mid();
    test_wrap();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/conway_board_loader.md
# conway_board_loader

Row-stream writer for the 16x16 toroidal life engine. It accepts one 16-bit board row per valid/ready handshake and assembles 16 rows into a shadow frame. It then drives the engine's `load`/`data` pair for exactly one cycle with the completed 256-bit board. It sits between the host/testbench row source and the life engine, and it is the only block that writes the engine's board.

## Interface
Parameters:
- `ROWS`, 16, board rows per frame
- `COLS`, 16, cells per row (row width)

Ports:
- `clk`  in  1  single clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high reset
- `in_valid`  in  1  row source has a row
- `in_ready`  out  1  loader accepts a row this cycle
- `in_row`  in  COLS  row cells; bit j = column j
- `in_last`  in  1  source marks final row of frame
- `load`  out  1  one-cycle load strobe to life engine
- `data`  out  ROWS*COLS  board to engine; row i at `data[COLS*i +: COLS]`
- `frame_err`  out  1  one-cycle pulse: framing error, frame discarded
- `frame_count`  out  8  completed frames loaded, wraps 255->0

## Operation
- Handshake: a row transfers on a rising edge where `in_valid && in_ready`. The source holds `in_row`/`in_last` stable while `in_valid && !in_ready`.
- States:
  - FILL: `in_ready`=1. Each accepted row is written to `shadow[COLS*row_idx +: COLS]` and `row_idx` increments.
  - LOAD: `in_ready`=0, `load`=1, `data` presents the new frame. Always returns to FILL next cycle.
- Frame completion: a row accepted with `row_idx==ROWS-1` and `in_last==1`:
  - `data` <= shadow with the final row merged in the same edge.
  - `row_idx` <= 0.
  - `frame_count` increments.
  - State goes to LOAD.
- Framing errors, both of which discard the frame:
  - `in_last==1` with `row_idx<ROWS-1` (short frame).
  - `in_last==0` with `row_idx==ROWS-1` (long frame).
  - On either error: `frame_err` pulses the following cycle, `row_idx` <= 0, state stays FILL, and `data`, `load` and `frame_count` are unchanged.
- `data` changes only on the edge entering LOAD. It holds its value between frames, so the engine may be reloaded from it.
- The shadow buffer is not cleared between frames; every location is overwritten before use.
- Reset values: state FILL, `row_idx` 0, `load` 0, `data` all-zero, shadow all-zero, `frame_err` 0, `frame_count` 0. `in_ready` is 1 in the first cycle after reset.
- Reset asserted mid-frame discards all partial rows. Reset during LOAD forces `load`=0 on the next edge and preserves no frame.

## Timing
- `load`, `frame_err` and `data` are registered. `in_ready` is decoded combinationally from state only and never depends on `in_valid`.
- Latency: the final row accepted at edge N gives `load`=1 with the new `data` during cycle N..N+1. The engine samples it at edge N+1, and `in_ready` returns to 1 after edge N+1.
- Throughput: a 16-row frame needs 17 cycles minimum (16 accepts plus 1 LOAD bubble).
- `in_valid` low in any cycle stalls the frame with no timeout; `row_idx` is held.
- `load` is never high on two consecutive cycles.
- `frame_err` and `load` are never high in the same cycle.

## Structure
- Shared `conway_pkg` holds:
  - `CONWAY_ROWS=16`, `CONWAY_COLS=16`, `CONWAY_CELLS=256`.
  - `typedef logic [CONWAY_COLS-1:0] conway_row_t`.
  - `typedef logic [CONWAY_CELLS-1:0] conway_board_t`.
  - State enum `conway_ldr_state_e {LDR_FILL, LDR_LOAD}`. The life engine imports the same board type.
- `row_idx` width is `$clog2(ROWS)`.
- Single module, no sub-modules; the row counter and framing check are too small to split out.

## Test plan
- Basic frame: rows i=0..15 with `in_row`=16'h0001<<i, `in_last` on row 15, `in_valid` held high -> one `load` pulse, `data` equals the diagonal pattern (bit 17*i set), `frame_count`=1, and `in_ready`=0 for exactly that one cycle.
- Back-to-back: two frames (all 16'hFFFF, then glider 16'h0002/16'h0004/16'h0007 in rows 0-2, others 0), `in_valid` continuously high -> `load` at cycles 17 and 34, `data` matches each frame, `frame_count`=2.
- Stalls: deassert `in_valid` for 3 cycles after rows 4 and 11 -> same `data` as the unstalled frame, `load` delayed by exactly 6 cycles.
- Framing errors:
  - `in_last` on row 9 -> `frame_err` pulse, no `load`, `data` unchanged; the next valid 16-row frame loads normally.
  - 16th row without `in_last` -> `frame_err` pulse.
- Reset mid-frame: `reset` after row 7 -> `data`=0, `frame_count`=0, `row_idx`=0; the next full frame loads correctly.
- Counter wrap: 256 valid frames -> `frame_count` reads 0 after the 256th `load`, and no `frame_err` is ever asserted.
